alu_seq_ctrl: RTL
=================

# alu_seq_ctrl

Sequencer that owns the shared 32-bit ALU and drives it on behalf of the execute stage. Single-cycle functs (AND/OR/ADD/SUB/SLT) pass through and register in one cycle. MULTU runs as a 32-step shift-add loop that reuses the ALU's ADD path to build a 64-bit HI/LO product. MFHI/MFLO read the product back.

## Interface
- No parameters; widths fixed at 32 data / 6 funct.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only when busy=0
- funct  in  6  operation: AND 36, OR 37, ADD 32, SUB 34, SLT 42, MULTU 25, MFHI 16, MFLO 18
- dataA  in  32  operand A (multiplicand for MULTU)
- dataB  in  32  operand B (multiplier for MULTU)
- busy  out  1  multiply loop in progress
- done  out  1  one-cycle pulse; result/hi/lo valid
- result  out  32  registered result of the last completed op
- hi, lo  out  32 each  product registers
- alu_a, alu_b  out  32  to ALU dataA/dataB
- alu_signal  out  6  to ALU Signal
- alu_out  in  32  from ALU dataOut (combinational, same cycle)

## Operation
- States: IDLE, MUL, DONE.
- ALU drive:
  - In IDLE/DONE: alu_a=dataA, alu_b=dataB, alu_signal=funct.
  - In MUL: alu_a=hi, alu_b=mcand, alu_signal=ADD (32).
- start with busy=0, funct in {36,37,32,34,42}: result<=alu_out; go to DONE.
- start, MULTU: mcand<=dataA, hi<=0, lo<=dataB, cnt<=0; go to MUL.
- start, MFHI / MFLO: result<=hi / lo; go to DONE.
- start, unrecognised funct: result<=0; go to DONE.
- MUL step, every cycle:
  - if lo[0]=1: carry=(alu_out < hi) unsigned; {hi,lo}<={carry, alu_out, lo[31:1]} dropping the bit shifted out, i.e. hi<={carry,alu_out[31:1]}, lo<={alu_out[0],lo[31:1]}.
  - else: hi<={1'b0,hi[31:1]}, lo<={hi[0],lo[31:1]}.
  - cnt increments. The step taken with cnt=31 moves to DONE and sets result<=lo (final).
- DONE: done=1 for that cycle. Next state is IDLE, or acts as IDLE if start=1 (back-to-back accepted).
- start while busy=1: ignored, no state change, no queuing.
- hi/lo change only under MULTU. Every other op leaves them intact.

## Timing
- Reset values: state IDLE; busy, done = 0; result, hi, lo, mcand = 0; cnt = 0.
- Single-cycle ops and MFHI/MFLO: start at cycle t, result and done at cycle t+1. Latency 1.
- MULTU: start at t. busy=1 in cycles t+1..t+32. done=1 and busy=0 at t+33, with hi/lo/result final.
- busy is a registered decode of state==MUL. done is a registered decode of state==DONE.
- Asynchronous reset mid-MUL: immediately IDLE, all registers cleared, no done.
- dataA/dataB/funct are only sampled on the start cycle, and may change freely during MUL.

## Structure
- Shared package alu_pkg: funct constants (AND, OR, ADD, SUB, SLT, MULTU, MFHI, MFLO) and the state enum. The ALU adopts the same constants.
- No sub-module. The ALU is instantiated beside this block in the parent, wired via alu_a/alu_b/alu_signal/alu_out.
- cnt is 5 bits. The carry comparator is local.

## Test plan
- Reset, then MULTU 7 x 6: busy high 32 cycles; at t+33 done=1, hi=0, lo=42, result=42.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001. Then MFHI: result=0xFFFFFFFE at t+1.
- SUB 5-7: result=0xFFFFFFFE, done at t+1. SLT 3,9: result=1. SLT 9,3: result=0. hi/lo unchanged.
- start ADD pulsed during MUL cycle 10: ignored, product unaffected, single done pulse at t+33.
- reset asserted at MUL cycle 15: outputs zero immediately. After release, MFLO returns 0.
- ADD issued in the DONE cycle of a multiply: accepted, done again the next cycle with the correct sum.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU function codes and sequencer state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [5:0] FUNCT_AND   = 6'd36;
  localparam logic [5:0] FUNCT_OR    = 6'd37;
  localparam logic [5:0] FUNCT_ADD   = 6'd32;
  localparam logic [5:0] FUNCT_SUB   = 6'd34;
  localparam logic [5:0] FUNCT_SLT   = 6'd42;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Functs whose answer comes straight from the ALU in the start cycle.
  function automatic logic is_single_cycle(input logic [5:0] f);
    return (f == FUNCT_AND) || (f == FUNCT_OR) || (f == FUNCT_ADD) ||
           (f == FUNCT_SUB) || (f == FUNCT_SLT);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequencer owning the shared 32-bit ALU: single-cycle ops, MULTU shift-add loop, MFHI/MFLO.
// Latency: 1 cycle for ALU ops and MFHI/MFLO; 33 cycles start-to-done for MULTU.
// Backpressure: start is dropped (not queued) while busy; a new start is taken in the done cycle.
//
// Ports:
//   clk, reset (async, active-low)
//   start, funct[5:0], dataA[31:0], dataB[31:0]   request, sampled only when not busy
//   busy, done, result[31:0], hi[31:0], lo[31:0]  registered status and results
//   alu_a, alu_b, alu_signal / alu_out            drive to / answer from the external ALU
module alu_seq_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_signal,
  input  logic [31:0] alu_out
);

  state_e      state_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] mcand_q;
  logic [4:0]  cnt_q;

  logic        carry;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  // During the loop the ALU computes hi + mcand; a wrapped sum is smaller
  // than either addend, which recovers the 33rd bit without a wider adder.
  assign carry = (alu_out < hi_q);

  // One shift-add step: {carry, hi, lo} >> 1 when adding, {hi, lo} >> 1 otherwise.
  always_comb begin
    hi_d = {1'b0, hi_q[31:1]};
    lo_d = {hi_q[0], lo_q[31:1]};
    if (lo_q[0]) begin
      hi_d = {carry, alu_out[31:1]};
      lo_d = {alu_out[0], lo_q[31:1]};
    end
  end

  always_comb begin
    alu_a      = dataA;
    alu_b      = dataB;
    alu_signal = funct;
    if (state_q == ST_MUL) begin
      alu_a      = hi_q;
      alu_b      = mcand_q;
      alu_signal = FUNCT_ADD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (start) begin
            if (is_single_cycle(funct)) begin
              result_q <= alu_out;
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
            end else if (funct == FUNCT_MULTU) begin
              mcand_q <= dataA;
              hi_q    <= '0;
              lo_q    <= dataB;
              cnt_q   <= '0;
              state_q <= ST_MUL;
              busy_q  <= 1'b1;
            end else if (funct == FUNCT_MFHI) begin
              result_q <= hi_q;
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
            end else if (funct == FUNCT_MFLO) begin
              result_q <= lo_q;
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
            end else begin
              result_q <= '0;
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q <= lo_d;
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule
